otter_exec_unit: RTL and testbench
==================================

Name: otter_exec_unit

Overview:
- Registered execute-stage datapath for the OTTER RV32I pipeline.
- Combines three functions in one block: the ALU, the branch address generator (JAL/JALR/branch targets) and the branch condition generator (eq/lt/ltu).
- Sits between the decode→execute pipeline register and the execute→memory register.
- All results are captured into one output register stage.

Parameters:
- XLEN, 32, datapath width; only 32 is required to be supported.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  operands on the inputs are valid this cycle
- alu_fun  in  4  ALU operation, encoded {ir[30], funct3}
- src_a  in  32  ALU operand A (already muxed)
- src_b  in  32  ALU operand B (already muxed)
- rs1  in  32  register rs1 data
- rs2  in  32  register rs2 data
- pc  in  32  address of the instruction in execute
- imm_i  in  32  sign-extended I-type immediate
- imm_b  in  32  sign-extended B-type immediate
- imm_j  in  32  sign-extended J-type immediate
- out_valid  out  1  registered copy of in_valid
- alu_result  out  32  ALU result
- jal_target  out  32  JAL target address
- jalr_target  out  32  JALR target address
- branch_target  out  32  conditional-branch target address
- br_eq  out  1  rs1 == rs2
- br_lt  out  1  rs1 < rs2, signed
- br_ltu  out  1  rs1 < rs2, unsigned

Behaviour:
- Latency is exactly 1 cycle. All outputs are registered and updated on every rising CLK edge in which RST=0, regardless of in_valid.
- out_valid <= in_valid on each such edge.
- Reset: on a rising edge with RST=1, every output is set to 0, including out_valid and all flags. Reset takes priority over in_valid; a transaction presented in the reset cycle is lost.
- ALU operations, selected by alu_fun; all arithmetic is modulo 2^32:
  - 0000 ADD: a+b
  - 1000 SUB: a-b
  - 0001 SLL: a << b[4:0]
  - 0010 SLT: signed a<b, result 1 or 0
  - 0011 SLTU: unsigned a<b, result 1 or 0
  - 0100 XOR
  - 0110 OR
  - 0111 AND
  - 0101 SRL: logical right shift by b[4:0]
  - 1101 SRA: arithmetic right shift by b[4:0]
  - 1001 COPY: result = a (used for LUI)
  - any other code: result = 0
- Shift amounts use only b[4:0]; b[31:5] is ignored.
- Branch address generator:
  - jal_target = pc + imm_j
  - branch_target = pc + imm_b
  - jalr_target = (rs1 + imm_i) with bit 0 forced to 0
  - All sums wrap modulo 2^32, with no overflow indication.
- Branch condition generator compares rs1 and rs2 only; src_a and src_b do not affect the flags. Two's-complement is used for br_lt.
- There is no handshake and no stall input. The block is a pure pipeline stage: back-to-back valid inputs produce back-to-back outputs.
- X-free requirement: every output is defined for all input values.

Optional Feature:
- Macro: OTTER_EXU_BRANCH_RESOLVE_EN.
- When defined, two ports are added:
  - input br_funct3 [2:0]
  - output br_taken, registered, reset to 0
- br_taken is decoded from the flags computed in the same cycle:
  - 000 BEQ: eq
  - 001 BNE: !eq
  - 100 BLT: lt
  - 101 BGE: !lt
  - 110 BLTU: ltu
  - 111 BGEU: !ltu
  - 010, 011: 0
- br_taken is not gated by in_valid; consumers qualify it with out_valid.
- When undefined, the ports do not exist and all other behaviour is identical.

Decomposition:
- Package otter_exu_pkg holds:
  - alu_fun_t enum with the 4-bit codes above
  - the funct3 branch encodings as localparams
- One combinational sub-module, otter_alu_core (alu_fun, a, b -> result). The address generator, comparator and output register remain in the top.

Test Plan:
- ADD/SUB wrap: a=0xFFFFFFFF, b=1, fun=0000 -> alu_result=0x00000000 one cycle later. Fun=1000 with a=0, b=1 -> 0xFFFFFFFF.
- Shifts: a=0x80000000, b=0x00000021 (amount 1). SRA -> 0xC0000000; SRL -> 0x40000000; SLL -> 0x00000000.
- Compare: rs1=0xFFFFFFFF, rs2=0x00000001 -> br_eq=0, br_lt=1, br_ltu=0. SLT/SLTU with the same values as a/b -> 1 and 0.
- Targets: pc=0x100, imm_j=0xFFFFFFF0, imm_b=0x20, rs1=0x2001, imm_i=0x4 -> jal_target=0xF0, branch_target=0x120, jalr_target=0x2004.
- Reset mid-stream: drive a valid ADD, then assert RST for one edge -> all outputs and out_valid=0. The next valid input appears 1 cycle after RST falls.
- With OTTER_EXU_BRANCH_RESOLVE_EN: rs1=5, rs2=5, br_funct3=001 -> br_taken=0; br_funct3=000 -> br_taken=1; br_funct3=010 -> br_taken=0.

Source files
------------

// File: rtl/otter_exu_pkg.sv
// Shared types and constants for the OTTER execute stage: ALU operation codes,
// branch funct3 encodings and the JALR target alignment helper.
package otter_exu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_COPY = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // JALR targets are halfword aligned: the computed sum has bit 0 cleared.
    function automatic logic [31:0] align_jalr(input logic [31:0] sum);
        return {sum[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/otter_alu_core.sv
// Combinational RV32I ALU; unused operation codes produce zero so the result
// is always defined.
module otter_alu_core
    import otter_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_fun,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = b[4:0];

    // Operation select; only the low five bits of b act as shift amount.
    always_comb begin
        result = {XLEN{1'b0}};
        case (alu_fun)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt_s;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SRL:  result = a >> shamt_s;
            ALU_SRA:  result = $signed(a) >>> shamt_s;
            ALU_COPY: result = a;
            default:  result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/otter_exec_unit.sv
// OTTER execute stage: ALU, branch target generator and branch comparator behind
// one output register. Define OTTER_EXU_BRANCH_RESOLVE_EN to add br_funct3/br_taken.
module otter_exec_unit
    import otter_exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    input  logic [3:0]      alu_fun,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] imm_b,
    input  logic [XLEN-1:0] imm_j,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] jal_target,
    output logic [XLEN-1:0] jalr_target,
    output logic [XLEN-1:0] branch_target,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_ltu
`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
    ,
    input  logic [2:0]      br_funct3,
    output logic            br_taken
`endif
);

    logic [XLEN-1:0] alu_s;
    logic [XLEN-1:0] jal_s;
    logic [XLEN-1:0] jalr_s;
    logic [XLEN-1:0] branch_s;
    logic            eq_s;
    logic            lt_s;
    logic            ltu_s;

    otter_alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .alu_fun (alu_fun),
        .a       (src_a),
        .b       (src_b),
        .result  (alu_s)
    );

    assign jal_s    = pc + imm_j;
    assign branch_s = pc + imm_b;
    assign jalr_s   = align_jalr(rs1 + imm_i);

    // Flags look only at the register operands, never at the muxed ALU inputs.
    assign eq_s  = (rs1 == rs2);
    assign lt_s  = ($signed(rs1) < $signed(rs2));
    assign ltu_s = (rs1 < rs2);

`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
    logic taken_s;

    // Branch decision from this cycle's flags; not qualified by in_valid.
    always_comb begin
        taken_s = 1'b0;
        case (br_funct3)
            BR_BEQ:  taken_s = eq_s;
            BR_BNE:  taken_s = ~eq_s;
            BR_BLT:  taken_s = lt_s;
            BR_BGE:  taken_s = ~lt_s;
            BR_BLTU: taken_s = ltu_s;
            BR_BGEU: taken_s = ~ltu_s;
            default: taken_s = 1'b0;
        endcase
    end

    // Output register for the branch decision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            br_taken <= 1'b0;
        end else begin
            br_taken <= taken_s;
        end
    end
`endif

    // Output register stage; loads every cycle, reset wins over a valid input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid     <= 1'b0;
            alu_result    <= {XLEN{1'b0}};
            jal_target    <= {XLEN{1'b0}};
            jalr_target   <= {XLEN{1'b0}};
            branch_target <= {XLEN{1'b0}};
            br_eq         <= 1'b0;
            br_lt         <= 1'b0;
            br_ltu        <= 1'b0;
        end else begin
            out_valid     <= in_valid;
            alu_result    <= alu_s;
            jal_target    <= jal_s;
            jalr_target   <= jalr_s;
            branch_target <= branch_s;
            br_eq         <= eq_s;
            br_lt         <= lt_s;
            br_ltu        <= ltu_s;
        end
    end

endmodule

// File: tb/tb_otter_exec_unit.sv
// Self-checking bench for otter_exec_unit: directed vector table, reset and
// in_valid sequences, then randomized stimulus against a behavioural model.
module tb_otter_exec_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [3:0]  alu_fun;
    logic [31:0] src_a, src_b, rs1, rs2, pc, imm_i, imm_b, imm_j;
    logic        out_valid;
    logic [31:0] alu_result, jal_target, jalr_target, branch_target;
    logic        br_eq, br_lt, br_ltu;
`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
    logic [2:0]  br_funct3;
    logic        br_taken;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    otter_exec_unit dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .alu_fun       (alu_fun),
        .src_a         (src_a),
        .src_b         (src_b),
        .rs1           (rs1),
        .rs2           (rs2),
        .pc            (pc),
        .imm_i         (imm_i),
        .imm_b         (imm_b),
        .imm_j         (imm_j),
        .out_valid     (out_valid),
        .alu_result    (alu_result),
        .jal_target    (jal_target),
        .jalr_target   (jalr_target),
        .branch_target (branch_target),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .br_ltu        (br_ltu)
`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
        ,
        .br_funct3     (br_funct3),
        .br_taken      (br_taken)
`endif
    );

    typedef struct packed {
        logic [3:0]  fun;
        logic [31:0] a, b, r1, r2, p, ii, ib, ij;
        logic [2:0]  f3;
        logic [31:0] e_alu, e_jal, e_jalr, e_br;
        logic        e_eq, e_lt, e_ltu, e_tk;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                         input logic [31:0] ii, input logic [31:0] ib, input logic [31:0] ij,
                         input logic [2:0] f3);
        in_valid = v; alu_fun = f; src_a = a; src_b = b; rs1 = r1; rs2 = r2;
        pc = p; imm_i = ii; imm_b = ib; imm_j = ij;
`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
        br_funct3 = f3;
`else
        if (f3 != 3'd0) begin
            // funct3 has no effect in this build
        end
`endif
    endtask

    // Behavioural model of the ALU from the operation definitions.
    function automatic logic [31:0] model_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [63:0] prod;
        logic [31:0] r;
        sh = int'(b % 32'd32);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a + (~b + 32'd1);
            4'b0001: begin prod = {32'd0, a} * (64'd1 << sh); return prod[31:0]; end
            4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0110: return a | b;
            4'b0111: return a & b;
            4'b0101: return a / (32'd1 << sh);
            4'b1101: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
                return r;
            end
            4'b1001: return a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ealu, input logic [31:0] ejal,
                             input logic [31:0] ejalr, input logic [31:0] ebr, input logic eeq,
                             input logic elt, input logic eltu, input logic etk);
        check({tag, ".out_valid"},     {31'd0, out_valid}, {31'd0, ev});
        check({tag, ".alu_result"},    alu_result, ealu);
        check({tag, ".jal_target"},    jal_target, ejal);
        check({tag, ".jalr_target"},   jalr_target, ejalr);
        check({tag, ".branch_target"}, branch_target, ebr);
        check({tag, ".br_eq"},         {31'd0, br_eq},  {31'd0, eeq});
        check({tag, ".br_lt"},         {31'd0, br_lt},  {31'd0, elt});
        check({tag, ".br_ltu"},        {31'd0, br_ltu}, {31'd0, eltu});
`ifdef OTTER_EXU_BRANCH_RESOLVE_EN
        check({tag, ".br_taken"},      {31'd0, br_taken}, {31'd0, etk});
`else
        if (etk === 1'bx) $display("note: %s taken expectation undefined", tag);
`endif
    endtask

    initial begin
        logic        v;
        logic [3:0]  f;
        logic [31:0] a, b, r1, r2, p, ii, ib, ij;
        logic [2:0]  f3;
        logic        eq, lt, ltu;

        //          fun      a             b             rs1           rs2           pc        imm_i     imm_b     imm_j         f3    alu           jal       jalr      br        eq    lt    ltu   tk
        tbl[0]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'h00000000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'h8, 32'h00000000, 32'h00000001, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'hFFFFFFFF, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4'hD, 32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'hC0000000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'h5, 32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'h40000000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'h1, 32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'h00000000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h0,   32'h0,   32'h0,   32'h0,        3'd4, 32'h00000001, 32'h0,   32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h0,   32'h0,   32'h0,   32'h0,        3'd7, 32'h00000000, 32'h0,   32'hFFFFFFFE, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{4'h9, 32'h12345000, 32'h00000000, 32'h00002001, 32'h0,        32'h100, 32'h4,   32'h20,  32'hFFFFFFF0, 3'd6, 32'h12345000, 32'hF0,  32'h2004, 32'h120, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'hA, 32'h00000005, 32'h00000003, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd1, 32'h00000000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd2, 32'h00000FF0, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'h6, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd3, 32'h0000FFF0, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'h7, 32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        32'h0,   32'h0,   32'h0,   32'h0,        3'd5, 32'h0000F000, 32'h0,   32'h0,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{4'h0, 32'h00000002, 32'h00000003, 32'h00000005, 32'h00000005, 32'h0,   32'h0,   32'h0,   32'h0,        3'd1, 32'h00000005, 32'h0,   32'h4,    32'h0,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{4'h0, 32'h00000002, 32'h00000003, 32'h00000005, 32'h00000005, 32'h0,   32'h0,   32'h0,   32'h0,        3'd0, 32'h00000005, 32'h0,   32'h4,    32'h0,   1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{4'h0, 32'h00000002, 32'h00000003, 32'h00000005, 32'h00000005, 32'h0,   32'h0,   32'h0,   32'h0,        3'd2, 32'h00000005, 32'h0,   32'h4,    32'h0,   1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        RST = 1'b1;
        drive(1'b1, 4'h0, 32'd1, 32'd2, 32'd3, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 3'd0);
        @(posedge CLK); #1;
        check_all("reset", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed table, back-to-back valid inputs
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            RST = 1'b0;
            drive(1'b1, tbl[i].fun, tbl[i].a, tbl[i].b, tbl[i].r1, tbl[i].r2, tbl[i].p,
                  tbl[i].ii, tbl[i].ib, tbl[i].ij, tbl[i].f3);
            @(posedge CLK); #1;
            check_all($sformatf("vec%0d", i), 1'b1, tbl[i].e_alu, tbl[i].e_jal, tbl[i].e_jalr,
                      tbl[i].e_br, tbl[i].e_eq, tbl[i].e_lt, tbl[i].e_ltu, tbl[i].e_tk);
        end

        // Reset mid-stream: valid ADD, then a valid input lost under reset, then recovery
        @(negedge CLK);
        drive(1'b1, 4'h0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        @(posedge CLK); #1;
        check("midrst.pre_alu", alu_result, 32'd3);
        @(negedge CLK);
        RST = 1'b1;
        drive(1'b1, 4'h0, 32'd7, 32'd8, 32'd9, 32'd1, 32'h40, 32'd3, 32'd4, 32'd5, 3'd1);
        @(posedge CLK); #1;
        check_all("midrst", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        drive(1'b1, 4'h0, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0);
        @(posedge CLK); #1;
        check_all("postrst", 1'b1, 32'd10, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Invalid input still updates the datapath registers
        @(negedge CLK);
        drive(1'b0, 4'h8, 32'd5, 32'd7, 32'd1, 32'd2, 32'h10, 32'd0, 32'd8, 32'd4, 3'd6);
        @(posedge CLK); #1;
        check_all("invalid", 1'b0, 32'hFFFFFFFE, 32'h14, 32'd0, 32'h18, 1'b0, 1'b1, 1'b1, 1'b1);

        // Randomized stimulus against the model
        for (int n = 0; n < 400; n++) begin
            v  = 1'($urandom_range(0, 1));
            f  = 4'($urandom_range(0, 15));
            a  = $urandom; b = $urandom; r1 = $urandom;
            r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom;
            p  = $urandom; ii = $urandom; ib = $urandom; ij = $urandom;
            f3 = 3'($urandom_range(0, 7));
            eq  = (r1 == r2);
            ltu = (r1 < r2);
            lt  = (r1[31] != r2[31]) ? r1[31] : ltu;
            @(negedge CLK);
            drive(v, f, a, b, r1, r2, p, ii, ib, ij, f3);
            @(posedge CLK); #1;
            check_all($sformatf("rnd%0d", n), v, model_alu(f, a, b), p + ij,
                      (r1 + ii) & 32'hFFFF_FFFE, p + ib, eq, lt, ltu, model_taken(f3, eq, lt, ltu));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
